// File: rtl/unsigned_16by8_seq_div.sv
// Restoring unsigned divider, one quotient bit per clock: recovers z / y and z % y
// from a DW-bit product and a VW-bit operand, with valid/ready handshakes on both sides.
module unsigned_16by8_seq_div #(
   parameter int DW = 16,
   parameter int VW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero,
   output logic          q_ovf
);

   // state  | meaning
   // S_IDLE | waiting for operands, in_ready high
   // S_BUSY | shifting/subtracting one quotient bit per cycle
   // S_DONE | result presented, out_valid high until accepted
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   logic [1:0]    state_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] dq_q;
   logic [VW:0]   r_q;
   logic [VW-1:0] divisor_q;

   logic [VW:0]   r_sh;
   logic [VW:0]   r_nx;
   logic [DW-1:0] dq_nx;
   logic          ge;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);

   always_comb begin
      r_sh  = {r_q[VW-1:0], dq_q[DW-1]};
      ge    = (r_sh >= {1'b0, divisor_q});
      r_nx  = ge ? (r_sh - {1'b0, divisor_q}) : r_sh;
      dq_nx = {dq_q[DW-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dq_q        <= '0;
         r_q         <= '0;
         divisor_q   <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         q_ovf       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  dq_q      <= dividend;
                  r_q       <= '0;
                  divisor_q <= divisor;
                  cnt_q     <= '0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[VW-1:0];
                     div_by_zero <= 1'b1;
                     q_ovf       <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               dq_q  <= dq_nx;
               r_q   <= r_nx;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  // remainder is always below the divisor, so the top bit is dropped
                  quotient    <= dq_nx;
                  remainder   <= r_nx[VW-1:0];
                  div_by_zero <= 1'b0;
                  q_ovf       <= |dq_nx[DW-1:VW];
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Bench for unsigned_16by8_seq_div: directed corner cases plus a sweep of every divisor,
// checked against plain z / y, z % y arithmetic.
module tb_unsigned_16by8_seq_div;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        q_ovf;

   int n_checks;
   int n_errors;

   unsigned_16by8_seq_div #(.DW(16), .VW(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .q_ovf       (q_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: integer division, with the divide-by-zero convention of all-ones quotient
   // and the low dividend byte as remainder.
   task automatic run_op(input logic [15:0] z, input logic [7:0] y, input int hold);
      int          t;
      int          lat;
      int unsigned exp_q;
      int unsigned exp_r;
      logic [15:0] q_seen;
      logic [7:0]  r_seen;

      if (y != 0) begin
         exp_q = int'(z) / int'(y);
         exp_r = int'(z) % int'(y);
      end else begin
         exp_q = 65535;
         exp_r = int'(z) % 256;
      end

      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      chk("in_ready_before_op", 32'(in_ready), 1);

      in_valid  = 1'b1;
      dividend  = z;
      divisor   = y;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);

      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (y != 0) chk("latency", 32'(lat), 16);
      else        chk("dz_latency_le1", 32'(lat <= 1), 1);

      chk("out_valid", 32'(out_valid), 1);
      chk("quotient", 32'(quotient), exp_q);
      chk("remainder", 32'(remainder), exp_r);
      chk("div_by_zero", 32'(div_by_zero), 32'(y == 0));
      chk("q_ovf", 32'(q_ovf), 32'(exp_q > 255));
      chk("in_ready_in_done", 32'(in_ready), 0);

      q_seen = quotient;
      r_seen = remainder;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
         tick();
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_q", 32'(quotient), 32'(q_seen));
         chk("hold_r", 32'(remainder), 32'(r_seen));
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      in_valid = 1'b0;

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("consumed_valid", 32'(out_valid), 0);
      chk("consumed_in_ready", 32'(in_ready), 1);
      chk("q_kept_in_idle", 32'(quotient), exp_q);
   endtask

   initial begin
      logic [7:0] xr;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_quotient", 32'(quotient), 0);
      chk("rst_remainder", 32'(remainder), 0);
      chk("rst_dbz", 32'(div_by_zero), 0);
      chk("rst_q_ovf", 32'(q_ovf), 0);
      rst_n = 1'b1;
      tick();

      run_op(16'd60026, 8'd251, 0);
      run_op(16'd65535, 8'd1, 0);
      run_op(16'd100, 8'd0, 0);
      run_op(16'd0, 8'd7, 0);
      run_op(16'd65025, 8'd255, 0);
      run_op(16'd1234, 8'd77, 10);

      // reset while busy at cnt=8 aborts without a result
      in_valid = 1'b1;
      dividend = 16'd60026;
      divisor  = 8'd251;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_in_ready", 32'(in_ready), 1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_no_result", 32'(out_valid), 0);
      run_op(16'd60026, 8'd251, 0);

      for (int y = 0; y < 256; y++) begin
         if (y % 2 == 0) begin
            xr = 8'($urandom);
            run_op(16'(int'(xr) * y), 8'(y), int'($urandom_range(0, 2)));
         end else begin
            run_op(16'($urandom), 8'(y), int'($urandom_range(0, 2)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
